// File: rtl/cpu.sv
// cpu: single-cycle 16-bit CPU with 16 registers, Z/C flags, OUT port and HLT
module cpu #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    output logic [15:0] prom_addr,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        halted
);
    logic [15:0] pc;
    logic [15:0] regs [16];
    logic        z, c;
    logic [3:0]  op, rs1, rd, rs2;
    logic [15:0] imm, a, b, res, pc_inc, pc_next;
    logic [16:0] sum;
    logic        wr, fl, c_new;

    assign op        = instruction[3:0];
    assign rs1       = instruction[7:4];
    assign rd        = instruction[11:8];
    assign rs2       = instruction[15:12];
    assign imm       = instruction[31:16];
    assign a         = regs[rs1];
    assign b         = regs[rs2];
    assign pc_inc    = pc + 16'd1;
    assign prom_addr = pc;

    // Decode: ALU result, carry, write/flag enables and next PC
    always_comb begin
        sum   = {1'b0, a} + {1'b0, (op == 4'h8) ? imm : b};
        res   = 16'h0;
        c_new = 1'b0;
        case (op)
            4'h1, 4'h8: {c_new, res} = sum;
            4'h2: begin
                res   = a - b;
                c_new = a < b;
            end
            4'h3: res = a & b;
            4'h4: res = a | b;
            4'h5: res = a ^ b;
            4'h6: res = a << imm[3:0];
            4'h7: res = a >> imm[3:0];
            4'hE: res = imm;
            default: res = 16'h0;
        endcase
        fl      = (op >= 4'h1) && (op <= 4'h8);
        wr      = (fl || op == 4'hE) && rd != 4'h0;
        pc_next = (op == 4'h9)               ? imm :
                  (op == 4'hA && z)          ? imm :
                  (op == 4'hB && !z)         ? imm :
                  (op == 4'hC && c)          ? imm :
                  (op == 4'hF)               ? pc  : pc_inc;
    end

    // Architectural state: reset, execute one instruction per edge, freeze when halted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            z         <= 1'b0;
            c         <= 1'b0;
            out_data  <= 16'h0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0;
        end else if (!halted) begin
            pc        <= pc_next;
            out_valid <= op == 4'hD;
            if (op == 4'hD) out_data <= a;
            if (op == 4'hF) halted <= 1'b1;
            if (wr) regs[rd] <= res;
            if (fl) begin
                z <= res == 16'h0;
                c <= c_new;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed and random checks of cpu against an instruction-level model
module tb_cpu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic [15:0] prom_addr, out_data;
    logic        out_valid, halted;

    cpu dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .prom_addr(prom_addr), .out_data(out_data),
        .out_valid(out_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int hcnt  = 0;
    logic [15:0] r [16];
    logic [15:0] m_pc, m_out;
    logic        m_z, m_c, m_ov, m_h;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [15:0] imm);
        return {imm, rs2, rd, rs1, op};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [31:0] ins);
        int a, b, sh, full;
        logic [15:0] res, imm, npc;
        logic [3:0] op, rd;
        op  = ins[3:0];
        rd  = ins[11:8];
        imm = ins[31:16];
        a   = int'(r[ins[7:4]]);
        b   = int'(r[ins[15:12]]);
        sh  = int'(imm[3:0]);
        if (!rst_n) begin
            foreach (r[i]) r[i] = 16'h0;
            m_pc = 16'h0; m_z = 0; m_c = 0; m_out = 0; m_ov = 0; m_h = 0;
        end else if (m_h) begin
            m_ov = 0;
        end else begin
            npc = m_pc + 16'd1;
            if (op == 4'h9) npc = imm;
            if (op == 4'hA && m_z) npc = imm;
            if (op == 4'hB && !m_z) npc = imm;
            if (op == 4'hC && m_c) npc = imm;
            if (op == 4'hF) begin npc = m_pc; m_h = 1; end
            full = 0;
            case (op)
                4'h1: full = a + b;
                4'h2: full = a - b;
                4'h3: full = a & b;
                4'h4: full = a | b;
                4'h5: full = a ^ b;
                4'h6: full = a << sh;
                4'h7: full = a >> sh;
                4'h8: full = a + int'(imm);
                default: full = 0;
            endcase
            res = full[15:0];
            if (op >= 4'h1 && op <= 4'h8) begin
                m_z = res == 16'h0;
                m_c = (op == 4'h1 || op == 4'h8) ? full > 65535 : (op == 4'h2) ? a < b : 1'b0;
                if (rd != 0) r[rd] = res;
            end
            if (op == 4'hE && rd != 0) r[rd] = imm;
            m_ov = op == 4'hD;
            if (m_ov) m_out = 16'(a);
            m_pc = npc;
        end
    endtask

    task automatic step(input logic [31:0] ins, input string tag);
        instruction = ins;
        model(ins);
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, prom_addr, m_pc);
        chk({tag, ".out_data"}, out_data, m_out);
        chk({tag, ".out_valid"}, 16'(out_valid), 16'(m_ov));
        chk({tag, ".halted"}, 16'(halted), 16'(m_h));
    endtask

    initial begin
        logic [31:0] ins;
        foreach (r[i]) r[i] = 16'h0;
        m_pc = 0; m_z = 0; m_c = 0; m_out = 0; m_ov = 0; m_h = 0;
        rst_n = 0;
        step(32'hFFFF_FFFF, "reset_over_hlt");
        chk("reset_pc", prom_addr, 16'h0000);
        rst_n = 1;
        step(32'hAAAA080E, "ldi_r8");
        step(32'h0000008D, "out_r8");
        chk("out_aaaa", out_data, 16'hAAAA);
        chk("out_pulse", 16'(out_valid), 16'h1);
        chk("pc_after_out", prom_addr, 16'h0002);
        step(enc(4'h0, 0, 0, 0, 0), "nop_clears_valid");
        step(enc(4'hE, 1, 0, 0, 16'hFFFF), "ldi_r1");
        step(enc(4'hE, 2, 0, 0, 16'h0001), "ldi_r2");
        step(enc(4'h1, 3, 1, 2, 0), "add_wrap");
        step(enc(4'hC, 0, 0, 0, 16'h0010), "bc_after_add");
        step(enc(4'hA, 0, 0, 0, 16'h0020), "bz_after_add");
        chk("bz_taken", prom_addr, 16'h0020);
        step(enc(4'hD, 0, 3, 0, 0), "out_r3_zero");
        step(enc(4'hE, 1, 0, 0, 16'h0002), "ldi_r1_2");
        step(enc(4'h2, 3, 2, 1, 0), "sub_borrow");
        step(enc(4'hD, 0, 3, 0, 0), "out_r3_ffff");
        chk("sub_result", out_data, 16'hFFFF);
        step(enc(4'hB, 0, 0, 0, 16'h0030), "bnz_after_sub");
        step(enc(4'hC, 0, 0, 0, 16'h0040), "bc_after_sub");
        chk("bc_taken", prom_addr, 16'h0040);
        step(enc(4'hE, 0, 0, 0, 16'h1234), "ldi_r0");
        step(enc(4'hD, 0, 0, 0, 0), "out_r0");
        chk("r0_zero", out_data, 16'h0000);
        step(enc(4'h9, 0, 0, 0, 16'hFFFF), "jmp_ffff");
        step(enc(4'h0, 0, 0, 0, 0), "nop_wrap");
        chk("pc_wrap", prom_addr, 16'h0000);
        rst_n = 0;
        step(enc(4'hE, 5, 0, 0, 16'h5555), "reset_mid");
        rst_n = 1;
        for (int i = 0; i < 5; i++) step(32'h0, "nop_to_5");
        step(enc(4'hF, 0, 0, 0, 0), "hlt");
        for (int i = 0; i < 12; i++) step($urandom, "halted_frozen");
        chk("halt_pc", prom_addr, 16'h0005);
        chk("halt_flag", 16'(halted), 16'h1);
        rst_n = 0;
        step($urandom, "reset_halted");
        chk("unhalt_pc", prom_addr, 16'h0000);
        rst_n = 1;
        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            if (ins[3:0] == 4'hF && $urandom_range(0, 7) != 0) ins[3:0] = 4'h0;
            hcnt  = m_h ? hcnt + 1 : 0;
            rst_n = !(hcnt > 3 || $urandom_range(0, 63) == 0);
            step(ins, "rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
